icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Instruction-cache controller between the IF stage and the 8-line direct-mapped instruction cache storage (156-bit entries: valid + 27-bit tag + 128-bit line of 4 instructions).
- Performs the tag compare and word select, and stalls the pipeline on a miss.
- Refills the line from instruction memory with four single-word handshaked reads, then writes the whole line into the storage through its active-low write port.

Parameters:
TAG_W, 27, tag width (word-address bits [31:5])
IDX_W, 3, line index width (word-address bits [4:2])
OFF_W, 2, word-in-line offset (word-address bits [1:0])
LINE_W, 128, line width (4 x 32-bit instructions)
CNT_W, 16, miss counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  IF presents a fetch address
req_addr  in  32  fetch word address (instruction index, not byte address)
instr_out  out  32  fetched instruction
instr_valid  out  1  instr_out valid this cycle
stall  out  1  hold PC/IF; upstream keeps req_addr stable while high
cache_hit  out  1  storage write strobe, active-low: 0 writes the line
cache_addr  out  3  storage index
cache_tag_in  out  27  tag to write
cache_data_in  out  128  line to write
cache_data_out  in  128  storage line read (combinational)
cache_tag_out  in  27  storage tag read
cache_valid  in  1  storage valid bit
mem_req  out  1  memory read request
mem_addr  out  32  memory word address
mem_ack  in  1  memory read data valid
mem_rdata  in  32  memory read data
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: tag=req_addr[31:5], idx=req_addr[4:2], off=req_addr[1:0]. Line word k is at bits [32k+31:32k].
- FSM states:
  - LOOKUP: cache_addr=req_addr[4:2]. hit_int = req_valid & cache_valid & (cache_tag_out==tag).
    - hit_int: instr_out = word off, instr_valid=1, stall=0, zero-cycle latency.
    - req_valid & !hit_int: stall=1, instr_valid=0; latch tag/idx; cnt<=0; miss_count++ (saturates at all-ones); next FILL.
    - !req_valid: stall=0, instr_valid=0.
  - FILL: stall=1, mem_req=1, mem_addr={tag_l, idx_l, cnt}; mem_addr is stable until mem_ack.
    - On mem_ack: buffer[cnt]<=mem_rdata; cnt++.
    - Ack with cnt==3: next WRITE.
    - mem_ack may arrive in the first FILL cycle or any later cycle. Acks outside FILL are ignored.
  - WRITE: stall=1, cache_hit=0, cache_addr=idx_l, cache_tag_in=tag_l, cache_data_in=buffer; next LOOKUP. The held request hits in the next cycle.
- cache_hit is 1 in every state except WRITE, including during rst.
- Outputs in reset: instr_out=0, instr_valid=0, stall=0, mem_req=0, mem_addr=0, cache_hit=1, cache_addr=0, cache_tag_in=0, cache_data_in=0, miss_count=0; state=LOOKUP, cnt=0, buffer=0.
- Miss latency: miss cycle + 4 acks (N cycles) + WRITE + hit cycle. With immediate acks: 1+4+1, and the instruction is delivered in the 7th cycle.
- Boundaries:
  - rst mid-FILL/WRITE: abort at once; mem_req drops the next cycle; the partial line is discarded; no cache write.
  - Miss on a valid line with a different tag: overwrite (evict). There is no write-back; the cache is read-only.
  - A change in req_addr while stall=1 is a protocol violation; the fill completes for the latched address.
  - miss_count at 16'hFFFF stays 16'hFFFF.
  - Any X on cache outputs while req_valid=0 must not propagate to instr_valid.

Decomposition:
- Package icache_pkg: TAG_W, IDX_W, OFF_W, LINE_W, WORDS_PER_LINE=4, state enum {LOOKUP, FILL, WRITE}, and address-field extract functions.
- One sub-module, icache_fill_buf: 2-bit word counter plus 4x32 line assembly register, with ports clr, ack, wdata, cnt, line, last.

Test Plan:
- Cold miss: rst, then req_addr=0x00000005 (idx 1, off 1), mem returns 0x11,0x22,0x33,0x44 with immediate ack -> mem_addr 0x4..0x7; cache_hit=0 one cycle with data_in=0x00000044_00000033_00000022_00000011; then instr_out=0x22, instr_valid=1; miss_count=1.
- Hit after fill: req_addr=0x00000007 -> instr_out=0x44 the same cycle, stall=0, no mem_req.
- Conflict eviction: req_addr=0x00000025 (same idx 1, tag 1) -> miss, refill from 0x24..0x27, tag_in=1; a re-request of 0x5 misses again; miss_count=3.
- Slow memory: ack 3 cycles after each request -> stall high for 1+16+1 cycles, mem_addr held stable between acks.
- Reset mid-fill: rst asserted after the 2nd ack -> next cycle mem_req=0, stall=0, cache_hit stays 1 (no write), miss_count=0.
- Idle/saturation: req_valid=0 -> instr_valid=0, stall=0. Force miss_count to 0xFFFF with 65535+ misses (or a backdoor preload), one more miss -> stays 0xFFFF.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg : shared geometry, FSM encoding and address-field helpers
// Rev 1.0
// ============================================================================
package icache_pkg;

    localparam int TAG_W          = 27;
    localparam int IDX_W          = 3;
    localparam int OFF_W          = 2;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        FILL   = 2'd1,
        WRITE  = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:5];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] a);
        return a[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fill_buf.sv
`default_nettype none
// ============================================================================
// icache_fill_buf : refill word counter and line assembly register
// Rev 1.0
// ============================================================================
module icache_fill_buf
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ack,
    input  logic [WORD_W-1:0] wdata,
    output logic [OFF_W-1:0]  cnt,
    output logic [LINE_W-1:0] line,
    output logic              last
);

    logic [OFF_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Each word slot captures only the ack that matches its position.
    for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_word
        logic [WORD_W-1:0] word_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
            end else if (ack && !clr && (cnt_q == OFF_W'(k))) begin
                word_q <= wdata;
            end
        end

        assign line[k*WORD_W +: WORD_W] = word_q;
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == {OFF_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// icache_ctrl : direct-mapped I-cache lookup, miss stall and line refill
// Rev 1.0
// ============================================================================
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic              stall,
    output logic              cache_hit,
    output logic [IDX_W-1:0]  cache_addr,
    output logic [TAG_W-1:0]  cache_tag_in,
    output logic [LINE_W-1:0] cache_data_in,
    input  logic [LINE_W-1:0] cache_data_out,
    input  logic [TAG_W-1:0]  cache_tag_out,
    input  logic              cache_valid,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  miss_count
);

    state_t             state_q;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   miss_count_q;
    logic [CNT_W-1:0]   miss_count_d;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               hit;
    logic               miss;
    logic               fill_ack;
    logic [OFF_W-1:0]   fill_cnt;
    logic [LINE_W-1:0]  fill_line;
    logic               fill_last;
    logic [WORD_W-1:0]  sel_word;

    assign req_tag = addr_tag(req_addr);
    assign req_idx = addr_idx(req_addr);
    assign req_off = addr_off(req_addr);

    // req_valid leads the AND so unknown storage outputs cannot leak when idle.
    assign hit      = req_valid & cache_valid & (cache_tag_out == req_tag);
    assign miss     = (state_q == LOOKUP) & req_valid & ~hit;
    assign fill_ack = (state_q == FILL) & mem_ack;
    assign sel_word = cache_data_out[{req_off, 5'd0} +: WORD_W];

    assign miss_count_d = (&miss_count_q) ? miss_count_q : miss_count_q + 1'b1;
    assign miss_count   = miss_count_q;

    icache_fill_buf u_fill_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (miss),
        .ack   (fill_ack),
        .wdata (mem_rdata),
        .cnt   (fill_cnt),
        .line  (fill_line),
        .last  (fill_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOOKUP;
            tag_q        <= '0;
            idx_q        <= '0;
            miss_count_q <= '0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (miss) begin
                        tag_q        <= req_tag;
                        idx_q        <= req_idx;
                        miss_count_q <= miss_count_d;
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (fill_ack && fill_last) begin
                        state_q <= WRITE;
                    end
                end
                WRITE:   state_q <= LOOKUP;
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // Outputs are forced to their idle values while rst is held so an
    // aborted refill can never strobe the storage write port.
    always_comb begin
        instr_out     = '0;
        instr_valid   = 1'b0;
        stall         = 1'b0;
        cache_hit     = 1'b1;
        cache_addr    = '0;
        cache_tag_in  = '0;
        cache_data_in = '0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        if (!rst) begin
            case (state_q)
                LOOKUP: begin
                    cache_addr = req_idx;
                    if (hit) begin
                        instr_valid = 1'b1;
                        instr_out   = sel_word;
                    end else if (req_valid) begin
                        stall = 1'b1;
                    end
                end
                FILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {tag_q, idx_q, fill_cnt};
                end
                WRITE: begin
                    stall         = 1'b1;
                    cache_hit     = 1'b0;
                    cache_addr    = idx_q;
                    cache_tag_in  = tag_q;
                    cache_data_in = fill_line;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_ctrl : directed self-checking bench with storage and memory models
// Rev 1.0
// ============================================================================
module tb_icache_ctrl;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic [31:0]   instr_out;
    logic          instr_valid;
    logic          stall;
    logic          cache_hit;
    logic [2:0]    cache_addr;
    logic [26:0]   cache_tag_in;
    logic [127:0]  cache_data_in;
    logic [127:0]  cache_data_out;
    logic [26:0]   cache_tag_out;
    logic          cache_valid;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [15:0]   miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    icache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .cache_hit      (cache_hit),
        .cache_addr     (cache_addr),
        .cache_tag_in   (cache_tag_in),
        .cache_data_in  (cache_data_in),
        .cache_data_out (cache_data_out),
        .cache_tag_out  (cache_tag_out),
        .cache_valid    (cache_valid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .miss_count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage model: combinational read, write on the active-low strobe.
    logic [127:0] st_data [8];
    logic [26:0]  st_tag  [8];
    logic [7:0]   st_valid = 8'h00;

    assign cache_data_out = st_data[cache_addr];
    assign cache_tag_out  = st_tag[cache_addr];
    assign cache_valid    = st_valid[cache_addr];

    always @(posedge clk) begin
        if (!cache_hit) begin
            st_data[cache_addr]  <= cache_data_in;
            st_tag[cache_addr]   <= cache_tag_in;
            st_valid[cache_addr] <= 1'b1;
        end
    end

    // Memory model: words 4..7 hold 0x11..0x44, all others 0xA5A5_0000 | addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [3:0] n;
        n = {2'b00, a[1:0]} + 4'd1;
        if (a[31:2] == 30'd1) return {24'd0, n, n};
        return 32'hA5A5_0000 | a;
    endfunction

    int          ack_delay = 0;
    int          wait_n    = 0;
    int          n_log     = 0;
    int          addr_jumps = 0;
    logic [31:0] log_addr [8];
    logic [31:0] prev_addr = '0;
    bit          hold = 1'b0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (hold && mem_addr != prev_addr) addr_jumps++;
            prev_addr = mem_addr;
            if (wait_n == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_n    = 0;
                if (n_log < 8) log_addr[n_log] = mem_addr;
                n_log++;
            end else begin
                mem_ack = 1'b0;
                wait_n++;
            end
            hold = !mem_ack;
        end else begin
            mem_ack = 1'b0;
            wait_n  = 0;
            hold    = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a missing address from a negedge and follows it to the hit cycle.
    task automatic miss_seq(input string tag, input logic [31:0] a, input int dly,
                            input logic [127:0] exp_line, input logic [31:0] exp_instr);
        int           stall_n;
        bit           wrote;
        logic [127:0] wline;
        logic [26:0]  wtag;
        stall_n   = 0;
        wrote     = 1'b0;
        wline     = '0;
        wtag      = '0;
        ack_delay = dly;
        n_log     = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (stall && stall_n < 100) begin
            if (!cache_hit) begin
                wrote = 1'b1;
                wline = cache_data_in;
                wtag  = cache_tag_in;
            end
            stall_n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " stall cycles"}, 128'(stall_n), 128'(1 + 4 * (dly + 1) + 1));
        chk({tag, " line written"}, 128'(wrote), 128'(1));
        chk({tag, " write data"}, wline, exp_line);
        chk({tag, " write tag"}, 128'(wtag), 128'(a[31:5]));
        chk({tag, " instr"}, 128'(instr_out), 128'(exp_instr));
        chk({tag, " instr_valid"}, 128'(instr_valid), 128'(1));
        chk({tag, " acks"}, 128'(n_log), 128'(4));
        for (int k = 0; k < 4; k++) begin
            chk({tag, " mem_addr"}, 128'(log_addr[k]), 128'({a[31:2], 2'(k)}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h5;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state, with a live request present.
        @(negedge clk);
        #1;
        chk("rst stall", 128'(stall), 128'(0));
        chk("rst mem_req", 128'(mem_req), 128'(0));
        chk("rst cache_hit", 128'(cache_hit), 128'(1));
        chk("rst instr_valid", 128'(instr_valid), 128'(0));
        chk("rst miss_count", 128'(miss_count), 128'(0));
        chk("rst cache_data_in", cache_data_in, 128'(0));
        @(negedge clk);
        rst = 1'b0;

        miss_seq("cold", 32'h5, 0, 128'h00000044_00000033_00000022_00000011, 32'h22);
        chk("cold miss_count", 128'(miss_count), 128'(1));

        @(negedge clk);
        req_addr = 32'h7;
        #1;
        chk("hit instr", 128'(instr_out), 128'(32'h44));
        chk("hit valid", 128'(instr_valid), 128'(1));
        chk("hit stall", 128'(stall), 128'(0));
        @(negedge clk);
        #1;
        chk("hit mem_req", 128'(mem_req), 128'(0));

        @(negedge clk);
        miss_seq("evict", 32'h25, 0,
                 128'hA5A50027_A5A50026_A5A50025_A5A50024, 32'hA5A50025);
        @(negedge clk);
        miss_seq("remiss", 32'h5, 0, 128'h00000044_00000033_00000022_00000011, 32'h22);
        chk("evict miss_count", 128'(miss_count), 128'(3));

        @(negedge clk);
        miss_seq("slow", 32'h8, 3,
                 128'hA5A5000B_A5A5000A_A5A50009_A5A50008, 32'hA5A50008);
        chk("slow addr held", 128'(addr_jumps), 128'(0));
        chk("slow miss_count", 128'(miss_count), 128'(4));

        // Idle with a resident line addressed: nothing may be delivered.
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'h5;
        #1;
        chk("idle instr_valid", 128'(instr_valid), 128'(0));
        chk("idle stall", 128'(stall), 128'(0));
        chk("idle mem_req", 128'(mem_req), 128'(0));

        // Reset after the second ack of a refill into line 3.
        @(negedge clk);
        ack_delay = 0;
        req_valid = 1'b1;
        req_addr  = 32'h4C;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("abort rst cache_hit", 128'(cache_hit), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort mem_req", 128'(mem_req), 128'(0));
        chk("abort stall", 128'(stall), 128'(0));
        chk("abort cache_hit", 128'(cache_hit), 128'(1));
        chk("abort miss_count", 128'(miss_count), 128'(0));
        chk("abort no write", 128'(st_valid[3]), 128'(0));
        @(negedge clk);
        #1;
        chk("abort mem_req later", 128'(mem_req), 128'(0));
        chk("abort no write later", 128'(st_valid[3]), 128'(0));

        // Saturation: preload one below all-ones, then two more misses.
        @(negedge clk);
        force dut.miss_count_q = 16'hFFFE;
        #1;
        release dut.miss_count_q;
        @(negedge clk);
        miss_seq("sat1", 32'h4C, 0,
                 128'hA5A5004F_A5A5004E_A5A5004D_A5A5004C, 32'hA5A5004C);
        chk("sat1 miss_count", 128'(miss_count), 128'(16'hFFFF));
        @(negedge clk);
        miss_seq("sat2", 32'h6D, 0,
                 128'hA5A5006F_A5A5006E_A5A5006D_A5A5006C, 32'hA5A5006D);
        chk("sat2 miss_count", 128'(miss_count), 128'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
